// File: rtl/input_channel_rc.sv
// input_channel_rc: per-input-port FIFO and XY route compute for the 5-port wormhole router.
// Optional macro INCH_DROPCNT_EN enables the saturating malformed-flit drop counter.
module input_channel_rc #(
    parameter int MYX   = 0,
    parameter int MYY   = 0,
    parameter int FLITW = 34,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [FLITW-1:0] in_flit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [FLITW-1:0] out_flit,
    output logic             out_valid,
    output logic [2:0]       port,
    output logic             req,
    input  logic             grt,
    input  logic             dn_ready,
    output logic [7:0]       drop_cnt
);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [3:0]  L_MYX   = 4'(MYX);
    localparam logic [3:0]  L_MYY   = 4'(MYY);

    logic [FLITW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_port;
    logic [2:0]       w_port_nxt;
    logic [2:0]       w_route;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_empty;
    logic [1:0]       w_type;
    logic [3:0]       w_dx;
    logic [3:0]       w_dy;

    assign w_empty   = (r_count == '0);
    assign in_ready  = (r_count != L_DEPTH);
    assign w_push    = in_valid & in_ready;
    assign out_flit  = r_mem[r_rd_ptr];
    assign w_type    = out_flit[FLITW-1 -: 2];
    assign w_dx      = out_flit[7:4];
    assign w_dy      = out_flit[3:0];
    assign out_valid = w_pop & ~w_drop;
    assign port      = r_port;
    assign req       = (r_state == S_ACTIVE);

    // XY dimension-order route of the flit at the FIFO head
    always_comb begin
        w_route = 3'd0;
        if (w_dx > L_MYX)
            w_route = 3'd3;
        else if (w_dx < L_MYX)
            w_route = 3'd1;
        else if (w_dy > L_MYY)
            w_route = 3'd4;
        else if (w_dy < L_MYY)
            w_route = 3'd2;
    end

    // next state, route latch and pop/drop decisions
    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_port;
        w_pop       = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_type[0]) begin
                        w_port_nxt  = w_route;
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_pop  = 1'b1;
                        w_drop = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (grt && dn_ready && !w_empty) begin
                    w_pop = 1'b1;
                    if (w_type[1])
                        w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_flit;
    end

    // FIFO pointers, occupancy, state and held route
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= S_IDLE;
            r_port   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_port  <= w_port_nxt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - (AW+1)'(1);
        end
    end

`ifdef INCH_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    // saturating count of body/tail flits discarded while idle
    always_ff @(posedge clk) begin
        if (!rst_)
            r_drop_cnt <= 8'h00;
        else if (w_drop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_input_channel_rc.sv
// tb_input_channel_rc: scoreboard bench for input_channel_rc (MYX=1, MYY=1).
// Packet-level reference model feeds an expected queue; a negedge monitor checks pops.
module tb_input_channel_rc;

    localparam int MYX = 1;
    localparam int MYY = 1;

    logic        clk;
    logic        rst_;
    logic [33:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] out_flit;
    logic        out_valid;
    logic [2:0]  port;
    logic        req;
    logic        grt;
    logic        dn_ready;
    logic [7:0]  drop_cnt;

    input_channel_rc #(
        .MYX(MYX), .MYY(MYY), .FLITW(34), .DEPTH(4), .AW(2)
    ) dut (
        .clk(clk), .rst_(rst_),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_valid(out_valid),
        .port(port), .req(req), .grt(grt), .dn_ready(dn_ready),
        .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [33:0] flit;
        logic [2:0]  port;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   pops   = 0;
    int   exp_drop = 0;
    bit   m_in_pkt = 0;
    logic [2:0] m_port = 3'd0;
    int   mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [2:0] route_of(input int dx, input int dy);
        if (dx > MYX) return 3'd3;
        if (dx < MYX) return 3'd1;
        if (dy > MYY) return 3'd4;
        if (dy < MYY) return 3'd2;
        return 3'd0;
    endfunction

    function automatic logic [33:0] mk(input logic [1:0] t,
                                       input logic [3:0] dx,
                                       input logic [3:0] dy);
        logic [23:0] r;
        r = 24'($urandom);
        return {t, r, dx, dy};
    endfunction

    function automatic logic [33:0] mkr(input logic [1:0] t);
        return mk(t, 4'($urandom), 4'($urandom));
    endfunction

    function automatic int exp_drop_cnt();
`ifdef INCH_DROPCNT_EN
        return (exp_drop > 255) ? 255 : exp_drop;
`else
        return 0;
`endif
    endfunction

    // reference model: consume an accepted flit at packet level
    task automatic model_accept(input logic [33:0] f);
        exp_t e;
        if (!m_in_pkt) begin
            if (f[32]) begin
                m_port = route_of(int'(f[7:4]), int'(f[3:0]));
                e.flit = f; e.port = m_port;
                exp_q.push_back(e);
                m_in_pkt = !f[33];
            end else begin
                exp_drop++;
            end
        end else begin
            e.flit = f; e.port = m_port;
            exp_q.push_back(e);
            if (f[33]) m_in_pkt = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // call at #1 after a posedge; returns at #1 after the accepting edge
    task automatic send(input logic [33:0] f);
        bit ok;
        ok = 0;
        in_flit  = f;
        in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        if (ok) model_accept(f);
        else chk("send_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target, input bit req_hi);
        bit ok;
        ok = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            #1;
            if (pops >= target) begin
                ok = 1;
                break;
            end
            if (req_hi) chk("req_held", 64'(req), 64'd1);
        end
        if (!ok) chk("pop_timeout", 64'(pops), 64'(target));
    endtask

    // pop-side scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_ && out_valid) begin
            pops++;
            chk("req_on_pop", 64'(req), 64'd1);
            chk("pop_allowed", 64'(grt & dn_ready), 64'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 64'(out_flit), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_flit", 64'(out_flit), 64'(e.flit));
                chk("port", 64'(port), 64'(e.port));
            end
        end
    end

    // downstream/grant driver for toggle and random phases
    initial begin
        forever begin
            step();
            if (mode == 1) begin
                dn_ready = ~dn_ready;
            end else if (mode == 2) begin
                grt      = ($urandom_range(0, 3) != 0);
                dn_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int len;
        rst_     = 1'b0;
        in_valid = 1'b0;
        in_flit  = '0;
        grt      = 1'b0;
        dn_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_ = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_port", 64'(port), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // single head+tail to the east, check latency
        step();
        grt = 1'b1;
        dn_ready = 1'b1;
        send(mk(2'b11, 4'd3, 4'd1));
        @(negedge clk);
        chk("t1_req_c1", 64'(req), 64'd0);
        chk("t1_ov_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_req_c2", 64'(req), 64'd1);
        chk("t1_port_c2", 64'(port), 64'd3);
        chk("t1_ov_c2", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("t1_req_c3", 64'(req), 64'd0);
        chk("t1_ov_c3", 64'(out_valid), 64'd0);
        chk("t1_in_ready_c3", 64'(in_ready), 64'd1);

        // 4-flit packet south, dn_ready toggling
        step();
        base = pops;
        mode = 1;
        send(mk(2'b01, 4'd1, 4'd0));
        send(mkr(2'b00));
        send(mkr(2'b00));
        send(mkr(2'b10));
        wait_pops(base + 4, 1'b1);
        @(negedge clk);
        chk("t2_req_after_tail", 64'(req), 64'd0);
        chk("t2_pops", 64'(pops - base), 64'd4);
        mode = 0;

        // fill FIFO with no grant
        step();
        grt = 1'b0;
        dn_ready = 1'b1;
        send(mk(2'b01, 4'd2, 4'd1));
        send(mkr(2'b00));
        send(mkr(2'b00));
        send(mkr(2'b00));
        @(negedge clk);
        chk("t3_full", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b1;
        in_flit  = mkr(2'b00);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_still_full", 64'(in_ready), 64'd0);
        step();
        grt = 1'b1;
        step();
        grt = 1'b0;
        @(negedge clk);
        chk("t3_ready_back", 64'(in_ready), 64'd1);
        step();
        grt      = 1'b1;
        in_valid = 1'b1;
        in_flit  = mkr(2'b00);
        model_accept(in_flit);
        step();
        grt      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_push_pop_same", 64'(in_ready), 64'd1);
        step();
        send(mkr(2'b00));
        @(negedge clk);
        chk("t3_full_again", 64'(in_ready), 64'd0);
        step();
        grt = 1'b1;
        base = pops;
        send(mkr(2'b10));
        wait_pops(base + 5, 1'b1);
        @(negedge clk);
        chk("t3_req_after_tail", 64'(req), 64'd0);

        // malformed flits while idle, then local head+tail
        step();
        base = pops;
        send(mkr(2'b10));
        send(mkr(2'b00));
        send(mk(2'b11, 4'd1, 4'd1));
        wait_pops(base + 1, 1'b0);
        @(negedge clk);
        chk("t4_drop_cnt", 64'(drop_cnt), 64'(exp_drop_cnt()));

        // mid-packet starvation holds req
        step();
        base = pops;
        send(mk(2'b01, 4'd0, 4'd5));
        send(mkr(2'b00));
        wait_pops(base + 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_req_starved", 64'(req), 64'd1);
            chk("t5_ov_starved", 64'(out_valid), 64'd0);
        end
        step();
        send(mkr(2'b10));
        wait_pops(base + 3, 1'b1);
        @(negedge clk);
        chk("t5_req_after_tail", 64'(req), 64'd0);

        // reset while active with 3 flits buffered
        step();
        grt = 1'b0;
        send(mk(2'b01, 4'd0, 4'd2));
        send(mkr(2'b00));
        send(mkr(2'b00));
        @(negedge clk);
        chk("t6_req_before_rst", 64'(req), 64'd1);
        step();
        rst_ = 1'b0;
        exp_q.delete();
        m_in_pkt = 0;
        exp_drop = 0;
        step();
        rst_ = 1'b1;
        @(negedge clk);
        chk("t6_req", 64'(req), 64'd0);
        chk("t6_port", 64'(port), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_drop_cnt", 64'(drop_cnt), 64'd0);
        step();
        grt = 1'b1;
        base = pops;
        send(mk(2'b11, 4'd1, 4'd2));
        wait_pops(base + 1, 1'b0);

        // randomized packets with strays and random flow control
        step();
        mode = 2;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 7) == 0)
                send(($urandom_range(0, 1) == 0) ? mkr(2'b00) : mkr(2'b10));
            len = $urandom_range(1, 5);
            if (len == 1) begin
                send(mk(2'b11, 4'($urandom_range(0, 3)),
                        4'($urandom_range(0, 3))));
            end else begin
                send(mk(2'b01, 4'($urandom_range(0, 3)),
                        4'($urandom_range(0, 3))));
                for (int b = 0; b < len - 2; b++)
                    send(mkr(2'b00));
                send(mkr(2'b10));
            end
            repeat ($urandom_range(0, 2)) step();
        end
        mode = 0;
        step();
        grt = 1'b1;
        dn_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        chk("rand_drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("rand_req_idle", 64'(req), 64'd0);
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop_cnt()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
